dmem_lsu: RTL and testbench

Load/store unit for the RISC-V core. It sits between the execute stage and the word-organised data memory, and it is the initiator on that memory's ADDR/RW/WD/RD port. The unit turns RV32I byte, halfword and word loads and stores into word accesses. Sub-word stores are done as read-modify-write, because the memory only writes whole words. Misaligned and out-of-range requests are rejected without touching memory.

---
 rtl/dmem_lsu_pkg.sv | 56 +++++
 rtl/dmem_lsu_fmt.sv | 43 ++++
 rtl/dmem_lsu.sv | 124 ++++++++++++
 tb/tb_dmem_lsu.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the load/store unit and the core decoder.
// Holds FUNCT3 encodings, FAULT codes, the LSU state encoding, the latched
// request payload and the request legality check.
package dmem_lsu_pkg;

  localparam int unsigned XLEN = 32;

  // RV32I load/store FUNCT3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    FAULT_OK       = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10,
    FAULT_ILLEGAL  = 2'b11
  } fault_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Request fields still needed after the accept edge
  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [1:0]  offset;
    logic [15:0] wdata_lo;
  } req_t;

  // Legality check, in priority order: illegal FUNCT3, misaligned, out of range
  function automatic fault_e check_req(input logic we, input logic [2:0] funct3,
                                       input logic [XLEN-1:0] addr,
                                       input logic [XLEN-1:0] last_word);
    fault_e f;
    f = FAULT_OK;
    if ((we && funct3[2]) || funct3 == 3'b011 || funct3[2:1] == 2'b11)
      f = FAULT_ILLEGAL;
    else if ((funct3[1:0] == 2'b01 && addr[0]) ||
             (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00))
      f = FAULT_MISALIGN;
    else if (addr > last_word)
      f = FAULT_RANGE;
    return f;
  endfunction

endpackage

// File: rtl/dmem_lsu_fmt.sv
// Combinational sub-word formatter.
// Ports: word (memory word), offset (byte offset), funct3 (access type),
//        wdata (low half of store data) -> load_data (extended load result),
//        store_word (word with the stored byte/half merged in).
module dmem_lsu_fmt
  import dmem_lsu_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  input  logic [15:0]     wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Load extract: select by offset, then sign- or zero-extend
  always_comb begin
    byte_sel  = word[{offset, 3'b000} +: 8];
    half_sel  = offset[1] ? word[31:16] : word[15:0];
    load_data = '0;
    case (funct3)
      F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LW:   load_data = word;
      F3_LBU:  load_data = {24'h0, byte_sel};
      F3_LHU:  load_data = {16'h0, half_sel};
      default: load_data = '0;
    endcase
  end

  // Store merge: funct3[0] distinguishes SH from SB
  always_comb begin
    store_word = word;
    if (funct3[0])
      store_word[{offset[1], 4'b0000} +: 16] = wdata;
    else
      store_word[{offset, 3'b000} +: 8] = wdata[7:0];
  end

endmodule

// File: rtl/dmem_lsu.sv
// RV32I load/store unit in front of a word-organised data memory.
// Ports: CLK/RST (sync active-high), REQ/WE/FUNCT3/ADDR/WDATA request,
//        BUSY/DONE/RDATA/FAULT status, MEM_ADDR/MEM_RW/MEM_WD/MEM_RD memory port.
// Sub-word stores are read-modify-write. All outputs are registered; DONE is
// raised on the edge that leaves the DONE state.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
)
(
  input  logic            CLK,
  input  logic            RST,
  input  logic            REQ,
  input  logic            WE,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] ADDR,
  input  logic [XLEN-1:0] WDATA,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RDATA,
  output logic [1:0]      FAULT,
  output logic [XLEN-1:0] MEM_ADDR,
  output logic            MEM_RW,
  output logic [XLEN-1:0] MEM_WD,
  input  logic [XLEN-1:0] MEM_RD
);

  localparam logic [XLEN-1:0] LAST_WORD = XLEN'(MEM_BYTES - 4);

  state_e          state_q, state_d;
  req_t            req_q, req_d;
  logic            done_d, mem_rw_d;
  logic [XLEN-1:0] rdata_d, mem_addr_d, mem_wd_d;
  logic [1:0]      fault_d;
  fault_e          chk;
  logic [XLEN-1:0] fmt_load, fmt_store;

  dmem_lsu_fmt u_fmt (
    .word       (MEM_RD),
    .offset     (req_q.offset),
    .funct3     (req_q.funct3),
    .wdata      (req_q.wdata_lo),
    .load_data  (fmt_load),
    .store_word (fmt_store)
  );

  // Next state and next values of every registered output
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    rdata_d    = RDATA;
    fault_d    = FAULT;
    mem_addr_d = MEM_ADDR;
    mem_rw_d   = 1'b0;
    mem_wd_d   = '0;
    done_d     = 1'b0;
    chk        = check_req(WE, FUNCT3, ADDR, LAST_WORD);
    case (state_q)
      ST_IDLE: begin
        if (REQ) begin
          req_d      = '{we: WE, funct3: FUNCT3, offset: ADDR[1:0], wdata_lo: WDATA[15:0]};
          mem_addr_d = {ADDR[XLEN-1:2], 2'b00};
          rdata_d    = '0;
          fault_d    = chk;
          if (chk != FAULT_OK) begin
            state_d = ST_DONE;
          end else if (WE && FUNCT3 == F3_SW) begin
            // Full-word store needs no read
            state_d  = ST_WR;
            mem_rw_d = 1'b1;
            mem_wd_d = WDATA;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (req_q.we) begin
          state_d  = ST_WR;
          mem_rw_d = 1'b1;
          mem_wd_d = fmt_store;
        end else begin
          state_d = ST_DONE;
          rdata_d = fmt_load;
        end
      end
      ST_WR: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset wins over any pending write
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      RDATA    <= '0;
      FAULT    <= 2'b00;
      MEM_ADDR <= '0;
      MEM_RW   <= 1'b0;
      MEM_WD   <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      BUSY     <= (state_d != ST_IDLE);
      DONE     <= done_d;
      RDATA    <= rdata_d;
      FAULT    <= fault_d;
      MEM_ADDR <= mem_addr_d;
      MEM_RW   <= mem_rw_d;
      MEM_WD   <= mem_wd_d;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu with a byte-array reference memory.
module tb_dmem_lsu;

  localparam int unsigned MEM_BYTES = 1024;
  localparam int unsigned WORDS     = MEM_BYTES / 4;

  logic        CLK = 1'b0;
  logic        RST, REQ, WE;
  logic [2:0]  FUNCT3;
  logic [31:0] ADDR, WDATA, RDATA, MEM_ADDR, MEM_WD, MEM_RD;
  logic        BUSY, DONE, MEM_RW;
  logic [1:0]  FAULT;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0]  mem [WORDS];
  byte unsigned ref_b [MEM_BYTES];

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  fault;
    int          acc;
    int          lat;
    string       name;
  } exp_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];

  dmem_lsu #(.MEM_BYTES(MEM_BYTES)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .FUNCT3(FUNCT3), .ADDR(ADDR),
    .WDATA(WDATA), .BUSY(BUSY), .DONE(DONE), .RDATA(RDATA), .FAULT(FAULT),
    .MEM_ADDR(MEM_ADDR), .MEM_RW(MEM_RW), .MEM_WD(MEM_WD), .MEM_RD(MEM_RD)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Word memory: combinational read, write on posedge unless in reset
  assign MEM_RD = MEM_RW ? 32'hDEAD_BEEF : mem[MEM_ADDR[9:2]];
  always @(posedge CLK) if (MEM_RW && !RST) mem[MEM_ADDR[9:2]] <= MEM_WD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int wa);
    return {ref_b[wa+3], ref_b[wa+2], ref_b[wa+1], ref_b[wa]};
  endfunction

  // Reference model: architectural result of one request, updates ref_b
  task automatic predict(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output exp_t e, output bit has_wr,
                         output wr_t w);
    int     size;
    longint v;
    e.rdata = '0; e.fault = 2'd0; e.acc = 0; e.name = "";
    has_wr = 1'b0; w.addr = '0; w.data = '0;
    size = 4;
    if ((we && f3[2]) || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) begin
      e.fault = 2'd3;
    end else begin
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      if (addr % size != 0) e.fault = 2'd1;
      else if (addr > MEM_BYTES - 4) e.fault = 2'd2;
      else if (!we) begin
        v = 0;
        for (int i = size - 1; i >= 0; i--) v = v * 256 + ref_b[int'(addr) + i];
        if (!f3[2] && size < 4 && v >= (64'sd1 <<< (8 * size - 1)))
          v = v - (64'sd1 <<< (8 * size));
        e.rdata = v[31:0];
      end else begin
        for (int i = 0; i < size; i++) ref_b[int'(addr) + i] = 8'(wd >> (8 * i));
        has_wr = 1'b1;
        w.addr = addr - (addr % 4);
        w.data = ref_word(int'(w.addr));
      end
    end
    e.lat = (e.fault != 2'd0) ? 1 : (!we || size == 4) ? 2 : 3;
  endtask

  // Called at a negedge; returns at a negedge where the unit is idle
  task automatic wait_idle();
    int g = 0;
    checks++;
    while (BUSY !== 1'b0 && g <= 20) begin
      @(negedge CLK);
      g++;
    end
    if (g > 20) begin
      failures++;
      $display("FAIL idle timeout: BUSY stuck at %b", BUSY);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    REQ = 1'b1; WE = we; FUNCT3 = f3; ADDR = addr; WDATA = wd;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input string name);
    exp_t e; bit hw; wr_t w;
    wait_idle();
    predict(we, f3, addr, wd, e, hw, w);
    e.acc  = cyc + 1;
    e.name = name;
    exp_q.push_back(e);
    if (hw) wr_q.push_back(w);
    drive(we, f3, addr, wd);
    @(negedge CLK);
    REQ = 1'b0;
  endtask

  // Completion monitor
  always @(negedge CLK) begin : done_mon
    exp_t e;
    if (DONE === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected DONE: got rdata %08h fault %0d expected no completion", RDATA, FAULT);
      end else begin
        e = exp_q.pop_front();
        chk({e.name, " rdata"}, RDATA, e.rdata);
        chk({e.name, " fault"}, 32'(FAULT), 32'(e.fault));
        chk({e.name, " latency"}, 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  // Memory write monitor
  always @(negedge CLK) begin : wr_mon
    wr_t w;
    if (MEM_RW === 1'b1) begin
      if (wr_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected write: got addr %08h data %08h expected none", MEM_ADDR, MEM_WD);
      end else begin
        w = wr_q.pop_front();
        chk("write addr", MEM_ADDR, w.addr);
        chk("write data", MEM_WD, w.data);
      end
    end
  end

  initial begin
    logic [31:0] val;
    int          bad;
    RST = 1'b1; REQ = 1'b0; WE = 1'b0; FUNCT3 = 3'd0; ADDR = '0; WDATA = '0;
    for (int wi = 0; wi < int'(WORDS); wi++) begin
      val = (wi == 1) ? 32'h0000_0009 : (wi == 2) ? 32'h80FF_7F01 : $urandom;
      mem[wi] = val;
      for (int b = 0; b < 4; b++) ref_b[wi*4 + b] = 8'(val >> (8 * b));
    end

    repeat (3) @(negedge CLK);
    chk("reset BUSY", 32'(BUSY), 32'd0);
    chk("reset DONE", 32'(DONE), 32'd0);
    chk("reset RDATA", RDATA, 32'd0);
    chk("reset FAULT", 32'(FAULT), 32'd0);
    chk("reset MEM_ADDR", MEM_ADDR, 32'd0);
    chk("reset MEM_RW", 32'(MEM_RW), 32'd0);
    chk("reset MEM_WD", MEM_WD, 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    issue(1'b0, 3'b010, 32'h4, 32'h0, "LW 0x4");
    issue(1'b0, 3'b000, 32'h9, 32'h0, "LB 0x9");
    issue(1'b0, 3'b000, 32'hA, 32'h0, "LB 0xA");
    issue(1'b0, 3'b100, 32'hA, 32'h0, "LBU 0xA");
    issue(1'b0, 3'b001, 32'hA, 32'h0, "LH 0xA");
    issue(1'b0, 3'b101, 32'h8, 32'h0, "LHU 0x8");
    issue(1'b1, 3'b000, 32'h6, 32'h0000_00AB, "SB 0x6");
    issue(1'b0, 3'b010, 32'h4, 32'h0, "LW 0x4 after SB");
    issue(1'b0, 3'b001, 32'h5, 32'h0, "LH 0x5");
    issue(1'b1, 3'b010, 32'h2, 32'h1234_5678, "SW 0x2");
    issue(1'b0, 3'b010, 32'h400, 32'h0, "LW 0x400");
    issue(1'b1, 3'b100, 32'h10, 32'h5555_5555, "store f3=100");
    issue(1'b0, 3'b011, 32'h10, 32'h0, "load f3=011");
    issue(1'b1, 3'b001, 32'h3FE, 32'h0000_BEEF, "SH 0x3FE");
    issue(1'b0, 3'b000, 32'h3FD, 32'h0, "LB 0x3FD");

    // REQ held high: a load every third edge, stores offered while busy must be dropped
    wait_idle();
    for (int k = 0; k < 9; k++) begin
      if (k % 3 == 0) begin
        exp_t e; bit hw; wr_t w;
        predict(1'b0, 3'b010, 32'h10, 32'h0, e, hw, w);
        e.acc = cyc + 1; e.name = "held LW";
        exp_q.push_back(e);
        drive(1'b0, 3'b010, 32'h10, 32'h0);
      end else begin
        drive(1'b1, 3'b010, 32'($urandom_range(0, 255)) << 2, $urandom);
      end
      @(negedge CLK);
    end
    REQ = 1'b0;

    // Reset during the RD of an SH
    wait_idle();
    drive(1'b1, 3'b001, 32'h22, 32'h0000_1234);
    @(negedge CLK);
    REQ = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    chk("rst-mid BUSY", 32'(BUSY), 32'd0);
    chk("rst-mid MEM_RW", 32'(MEM_RW), 32'd0);
    chk("rst-mid DONE", 32'(DONE), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst-mid word unchanged", mem[8], ref_word(32));
    issue(1'b0, 3'b101, 32'h22, 32'h0, "LHU 0x22 after reset");

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, MEM_BYTES + 7));
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, "random");
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge CLK);
    end

    for (int g = 0; g < 50 && exp_q.size() != 0; g++) @(negedge CLK);
    @(negedge CLK);
    chk("pending completions", 32'(exp_q.size()), 32'd0);
    chk("pending writes", 32'(wr_q.size()), 32'd0);
    bad = 0;
    for (int wi = 0; wi < int'(WORDS); wi++)
      if (mem[wi] !== ref_word(wi * 4)) bad++;
    chk("memory image words differing", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
